rd_burst_master: RTL and testbench
==================================

# rd_burst_master

Parametrised Avalon-MM burst read master that copies a byte range `[pkt_begin, pkt_end)` from host memory into the capture FIFO, one data word per FIFO write. It replaces the fixed 32-bit, 16-beat read controller and adds:
- configurable data width and maximum burst length;
- burst splitting on `MAX_BURST` address boundaries;
- FIFO backpressure gating per burst;
- packet framing (`sop`/`eop`/`empty`);
- error reporting for malformed requests.

## Interface
- `DATA_W`, 32: Avalon data width in bits; power of 2, 32..256. `BYTES = DATA_W/8`.
- `ADDR_W`, 32: byte address width.
- `MAX_BURST`, 16: maximum beats per burst; power of 2, 1..256.
- `LEN_W`, 16: width of the byte-length arithmetic; lengths of 2^LEN_W bytes or more are errors.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `pkt_begin`  in  ADDR_W  first byte address; must be BYTES-aligned.
- `pkt_end`  in  ADDR_W  one past the last byte.
- `busy`  out  1  high from start acceptance until the cycle after `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: request rejected, no reads issued.
- `fifo_data`  out  DATA_W  registered copy of `avm_readdata`.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_sop`  out  1  qualifies the first word of the packet.
- `fifo_eop`  out  1  qualifies the last word of the packet.
- `fifo_empty`  out  log2(BYTES)  invalid trailing bytes in the eop word; 0 otherwise.
- `fifo_almost_full`  in  1  FIFO cannot accept another `MAX_BURST` words.
- `avm_address`  out  ADDR_W  burst start byte address.
- `avm_read`  out  1  read request.
- `avm_burstcount`  out  log2(MAX_BURST)+1  beats in the burst.
- `avm_readdata`  in  DATA_W  read data.
- `avm_readdatavalid`  in  1  read data valid.
- `avm_waitrequest`  in  1  slave stall.

## Operation
- Reset values: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE: on `start`, register `pkt_begin`/`pkt_end`, set `busy`, go to CHECK.
  - CHECK (1 cycle): set `L = pkt_end - pkt_begin`.
    - Error if `pkt_end < pkt_begin`, `pkt_begin % BYTES != 0`, or `L >= 2^LEN_W`: go to DONE with `err = 1`.
    - If `L == 0`: go to DONE with `err = 0`.
    - Otherwise: `words = ceil(L/BYTES)`, `last_empty = (BYTES - L%BYTES) % BYTES`, go to ISSUE.
  - ISSUE: wait while `fifo_almost_full` is high, with `avm_read` low. Otherwise drive the burst and go to WAIT_DATA once `avm_waitrequest` is low:
    - `avm_read = 1`;
    - `avm_address` = current word address;
    - `avm_burstcount = min(words_left, MAX_BURST - (word_index % MAX_BURST))`, where `word_index = address/BYTES`.
  - WAIT_DATA: count `avm_readdatavalid` beats. On the last beat of the burst, add `burstcount*BYTES` to the address and subtract `burstcount` from `words_left`. If `words_left` is now 0, go to DONE; else go to ISSUE.
  - DONE (1 cycle): `done = 1`; `err` as determined; go to IDLE. `busy` is low on the following cycle.
- Only one burst is outstanding at any time. No burst crosses a `MAX_BURST*BYTES` aligned boundary.
- FIFO path: `fifo_wr`, `fifo_data`, `fifo_sop`, `fifo_eop` and `fifo_empty` are registered one cycle after `avm_readdatavalid`, which is honoured only in WAIT_DATA.
  - `fifo_sop` on beat 0 of the packet.
  - `fifo_eop` on beat `words-1`, with `fifo_empty = last_empty` on that beat.
  - A one-word packet has `sop` and `eop` set together.
- Ignored inputs: `start` outside IDLE; `avm_readdatavalid` outside WAIT_DATA (e.g. stale data after reset). `fifo_almost_full` is never re-checked inside a burst.
- Async reset mid-transfer: immediate return to IDLE with all outputs 0. The next `start` is accepted normally.

## Timing
- Start accepted at edge t gives CHECK at t+1 and, for a valid non-empty request, `avm_read` high at t+2.
- `avm_address`, `avm_burstcount` and `avm_read` are held stable while `avm_waitrequest` is high.
- `fifo_wr` follows each `avm_readdatavalid` by exactly 1 cycle.
- On the final beat at cycle k: `fifo_wr` with `eop` and `done` are both high at k+1, and `busy` is low at k+2.
- Between bursts: last beat at k puts ISSUE at k+1, giving `avm_read` at k+1 if `fifo_almost_full` is low.
- Error or zero-length request: `done` at t+2, with no `avm_read` and no `fifo_wr`.

## Test plan
- `DATA_W=32`, `MAX_BURST=16`, begin 0x1000, end 0x1040 -> one burst at 0x1000 with burstcount 16; 16 `fifo_wr`; sop on beat 0; eop with empty=0 on beat 15; one `done` pulse with err=0.
- Begin 0x1000, end 0x100A -> burstcount 3; eop on the 3rd word with empty=2.
- Boundary split: begin 0x1030, end 0x1070 -> burst at 0x1030 with burstcount 4, then 0x1040 with burstcount 12; 16 words total.
- Begin 0x2000, end 0x2080; `fifo_almost_full` raised after the first burst's last beat and held 10 cycles -> `avm_read` stays low for those 10 cycles. Second burst at 0x2040 with burstcount 16 on the first low cycle.
- `avm_waitrequest` held 5 cycles on a burst -> address, burstcount and read constant throughout. `start` pulsed while busy -> ignored.
- Errors and reset:
  - end<begin -> `done` with err=1 at t+2, no read.
  - begin 0x1002 -> err=1.
  - end==begin -> `done` with err=0.
  - Reset asserted mid-burst -> outputs 0 immediately; stale `avm_readdatavalid` produces no `fifo_wr`; a new request then completes.

Source files
------------

// File: rtl/rd_burst_master.sv
// Avalon-MM burst read master: copies bytes [pkt_begin, pkt_end) into a packet
// FIFO, splitting bursts on MAX_BURST word boundaries and framing with sop/eop.
module rd_burst_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           pkt_begin,
  input  logic [ADDR_W-1:0]           pkt_end,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [DATA_W-1:0]           fifo_data,
  output logic                        fifo_wr,
  output logic                        fifo_sop,
  output logic                        fifo_eop,
  output logic [$clog2(DATA_W/8)-1:0] fifo_empty,
  input  logic                        fifo_almost_full,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_read,
  output logic [$clog2(MAX_BURST):0]  avm_burstcount,
  input  logic [DATA_W-1:0]           avm_readdata,
  input  logic                        avm_readdatavalid,
  input  logic                        avm_waitrequest
);

  localparam int BYTES   = DATA_W / 8;
  localparam int EMPTY_W = $clog2(BYTES);
  localparam int BC_W    = $clog2(MAX_BURST) + 1;
  localparam int CW      = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  begin_q, begin_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   words_left_q, words_left_d;
  logic [EMPTY_W-1:0] last_empty_q, last_empty_d;
  logic               err_q, err_d;
  logic               sop_pend_q, sop_pend_d;
  logic               issuing_q, issuing_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic [BC_W-1:0]    beat_q, beat_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic               fifo_sop_q, fifo_sop_d;
  logic               fifo_eop_q, fifo_eop_d;
  logic [EMPTY_W-1:0] fifo_empty_q, fifo_empty_d;
  logic [DATA_W-1:0]  fifo_data_q, fifo_data_d;

  logic [CW-1:0]      len, words, word_mod, room;
  logic [BC_W-1:0]    burst_len;
  logic               rd_req, last_beat;

  // Once a burst is presented it stays up through waitrequest even if the
  // FIFO later reports almost-full, so the Avalon command never changes.
  assign rd_req    = (state_q == S_ISSUE) && (issuing_q || !fifo_almost_full);
  assign last_beat = (state_q == S_WAIT) && avm_readdatavalid &&
                     (beat_q == bc_q - BC_W'(1));

  always_comb begin
    len       = CW'(end_q) - CW'(begin_q);
    words     = (len + CW'(BYTES - 1)) >> EMPTY_W;
    word_mod  = CW'(addr_q >> EMPTY_W) & CW'(MAX_BURST - 1);
    room      = CW'(MAX_BURST) - word_mod;
    burst_len = (CW'(words_left_q) < room) ? BC_W'(words_left_q) : BC_W'(room);
  end

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    begin_d      = begin_q;
    end_d        = end_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    last_empty_d = last_empty_q;
    err_d        = err_q;
    sop_pend_d   = sop_pend_q;
    issuing_d    = 1'b0;
    bc_d         = bc_q;
    beat_d       = beat_q;
    fifo_wr_d    = 1'b0;
    fifo_sop_d   = 1'b0;
    fifo_eop_d   = 1'b0;
    fifo_empty_d = '0;
    fifo_data_d  = fifo_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          begin_d = pkt_begin;
          end_d   = pkt_end;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((end_q < begin_q) || (|begin_q[EMPTY_W-1:0]) || (|(len >> LEN_W))) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (len == '0) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          err_d        = 1'b0;
          addr_d       = begin_q;
          words_left_d = LEN_W'(words);
          // (BYTES - L%BYTES) % BYTES is just the low bits of -L.
          last_empty_d = EMPTY_W'(CW'(0) - len);
          sop_pend_d   = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rd_req && !avm_waitrequest) begin
          bc_d    = burst_len;
          beat_d  = '0;
          state_d = S_WAIT;
        end else if (rd_req) begin
          issuing_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (avm_readdatavalid) begin
          fifo_wr_d   = 1'b1;
          fifo_data_d = avm_readdata;
          fifo_sop_d  = sop_pend_q;
          sop_pend_d  = 1'b0;
          beat_d      = beat_q + BC_W'(1);
          if (last_beat) begin
            beat_d       = '0;
            addr_d       = addr_q + (ADDR_W'(bc_q) << EMPTY_W);
            words_left_d = words_left_q - LEN_W'(bc_q);
            if (words_left_q == LEN_W'(bc_q)) begin
              fifo_eop_d   = 1'b1;
              fifo_empty_d = last_empty_q;
              state_d      = S_DONE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      begin_q      <= '0;
      end_q        <= '0;
      addr_q       <= '0;
      words_left_q <= '0;
      last_empty_q <= '0;
      err_q        <= 1'b0;
      sop_pend_q   <= 1'b0;
      issuing_q    <= 1'b0;
      bc_q         <= '0;
      beat_q       <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_sop_q   <= 1'b0;
      fifo_eop_q   <= 1'b0;
      fifo_empty_q <= '0;
      fifo_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      begin_q      <= begin_d;
      end_q        <= end_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      last_empty_q <= last_empty_d;
      err_q        <= err_d;
      sop_pend_q   <= sop_pend_d;
      issuing_q    <= issuing_d;
      bc_q         <= bc_d;
      beat_q       <= beat_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_sop_q   <= fifo_sop_d;
      fifo_eop_q   <= fifo_eop_d;
      fifo_empty_q <= fifo_empty_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = done && err_q;
  assign fifo_wr        = fifo_wr_q;
  assign fifo_sop       = fifo_sop_q;
  assign fifo_eop       = fifo_eop_q;
  assign fifo_empty     = fifo_empty_q;
  assign fifo_data      = fifo_data_q;
  assign avm_read       = rd_req;
  assign avm_address    = addr_q;
  assign avm_burstcount = burst_len;

endmodule

// File: tb/tb_rd_burst_master.sv
// Scoreboard bench for rd_burst_master: a memory-slave model answers bursts,
// a byte-range reference model predicts bursts, FIFO words and completions.
`timescale 1ns/1ps
module tb_rd_burst_master;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = 16;
  localparam int BYTES     = DATA_W / 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pkt_begin = '0, pkt_end = '0;
  logic        busy, done, err;
  logic [31:0] fifo_data;
  logic        fifo_wr, fifo_sop, fifo_eop;
  logic [1:0]  fifo_empty;
  logic        fifo_almost_full = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [4:0]  avm_burstcount;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;

  rd_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .busy(busy), .done(done), .err(err), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .fifo_sop(fifo_sop), .fifo_eop(fifo_eop), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .avm_address(avm_address), .avm_read(avm_read),
    .avm_burstcount(avm_burstcount), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int bc; } burst_t;
  typedef struct { logic [31:0] data; logic sop; logic eop; logic [1:0] empty; } word_t;
  typedef struct { logic err; logic short_req; int start_cyc; } done_t;

  burst_t      exp_burst[$];
  word_t       exp_word[$];
  done_t       exp_done[$];
  logic [31:0] beat_addr[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int exp_read_cyc = -1, exp_busy_cyc = -1;
  int wait_force = 0, stale_n = 0, af_cnt = 0;
  logic af_arm = 1'b0, af_drop_expect = 1'b0, rdv_stale = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: derive bursts and framed words straight from the byte range.
  task automatic model_req(input logic [31:0] b, input logic [31:0] e);
    done_t d;
    word_t w;
    burst_t bu;
    longint len;
    int words, left, idx, room, n, last_empty;
    logic [31:0] a;
    len = longint'(e) - longint'(b);
    d.start_cyc = cyc;
    if (len < 0 || (b % BYTES) != 0 || len >= (longint'(1) << LEN_W)) begin
      d.err = 1'b1; d.short_req = 1'b1;
    end else if (len == 0) begin
      d.err = 1'b0; d.short_req = 1'b1;
    end else begin
      d.err = 1'b0; d.short_req = 1'b0;
      words      = int'((len + BYTES - 1) / BYTES);
      last_empty = int'((BYTES - len % BYTES) % BYTES);
      a = b; left = words; idx = 0;
      while (left > 0) begin
        room = MAX_BURST - int'((a / BYTES) % MAX_BURST);
        n = (left < room) ? left : room;
        bu.addr = a; bu.bc = n;
        exp_burst.push_back(bu);
        for (int j = 0; j < n; j++) begin
          w.data  = mem_word(a + 32'(BYTES * j));
          w.sop   = (idx == 0);
          w.eop   = (idx == words - 1);
          w.empty = w.eop ? 2'(last_empty) : 2'd0;
          exp_word.push_back(w);
          idx++;
        end
        a = a + 32'(BYTES * n);
        left -= n;
      end
      exp_read_cyc = cyc + 2;
    end
    exp_busy_cyc = cyc + 1;
    exp_done.push_back(d);
  endtask

  task automatic flush();
    exp_burst.delete(); exp_word.delete(); exp_done.delete(); beat_addr.delete();
    exp_read_cyc = -1; exp_busy_cyc = -1; af_arm = 1'b0; af_cnt = 0; af_drop_expect = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, err, fifo_wr, fifo_sop, fifo_eop, fifo_empty,
                              avm_read, avm_burstcount}), 64'd0);
    check({tag, "_data"}, 64'({fifo_data, avm_address}), 64'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_outputs_zero("reset_outputs");
    flush();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_req(input logic [31:0] b, input logic [31:0] e, input int wf);
    int k = 0;
    while ((busy || exp_done.size() != 0) && k < 3000) begin
      @(posedge clk); k++;
    end
    @(posedge clk); #1;
    start = 1'b1; pkt_begin = b; pkt_end = e; wait_force = wf;
    model_req(b, e);
    @(posedge clk); #1;
    start = 1'b0; pkt_begin = $urandom; pkt_end = $urandom;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_done.size() != 0 && k < 3000) begin
      @(posedge clk); k++;
    end
    check("done_pending", 64'(exp_done.size()), 64'd0);
    if (exp_done.size() != 0) reset_pulse();
  endtask

  // Memory slave: random waitrequest, gapped read data, FIFO almost-full injection.
  always begin
    @(posedge clk); #2;
    if (!reset) begin
      avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0; fifo_almost_full = 1'b0; rdv_stale = 1'b0;
    end else begin
      if (af_cnt > 0) begin fifo_almost_full = 1'b1; af_cnt--; end
      else fifo_almost_full = 1'b0;
      if (wait_force > 0) begin avm_waitrequest = 1'b1; wait_force--; end
      else avm_waitrequest = ($urandom_range(0, 3) == 0);
      rdv_stale = 1'b0;
      if (stale_n > 0) begin
        avm_readdatavalid = 1'b1; avm_readdata = $urandom; rdv_stale = 1'b1; stale_n--;
      end else if (beat_addr.size() != 0 && $urandom_range(0, 3) != 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = mem_word(beat_addr.pop_front());
        if (beat_addr.size() == 0 && af_arm) begin af_arm = 1'b0; af_cnt = 10; end
      end else begin
        avm_readdatavalid = 1'b0;
      end
    end
  end

  // Monitor: compares DUT activity against the scoreboard queues.
  logic        prev_read = 0, prev_wait = 0, rdv_prev = 0, stale_prev = 0, af_prev = 0, done_prev = 0;
  logic [31:0] prev_addr = '0;
  logic [4:0]  prev_bc = '0;
  word_t       mw;
  burst_t      mb;
  done_t       md;

  always @(negedge clk) begin
    if (!reset) begin
      prev_read = 0; prev_wait = 0; rdv_prev = 0; stale_prev = 0; af_prev = 0; done_prev = 0;
    end else begin
      if (rdv_prev || fifo_wr)
        check("fifo_wr_latency", 64'(fifo_wr), 64'(rdv_prev && !stale_prev));
      if (fifo_wr) begin
        check("fifo_wr_expected", 64'(exp_word.size() != 0), 64'd1);
        if (exp_word.size() != 0) begin
          mw = exp_word.pop_front();
          check("fifo_word", 64'({fifo_data, fifo_sop, fifo_eop, fifo_empty}),
                64'({mw.data, mw.sop, mw.eop, mw.empty}));
        end
      end
      if (prev_read && prev_wait)
        check("avm_hold", 64'({avm_read, avm_address, avm_burstcount}), 64'({1'b1, prev_addr, prev_bc}));
      if (fifo_almost_full && !(prev_read && prev_wait))
        check("af_gate", 64'(avm_read), 64'd0);
      if (af_drop_expect && af_prev && !fifo_almost_full) begin
        check("af_release", 64'(avm_read), 64'd1);
        af_drop_expect = 1'b0;
      end
      if (exp_read_cyc == cyc) begin
        check("read_latency", 64'(avm_read), 64'd1);
        exp_read_cyc = -1;
      end
      if (exp_busy_cyc == cyc) begin
        check("busy_on_accept", 64'(busy), 64'd1);
        exp_busy_cyc = -1;
      end
      if (avm_read && !avm_waitrequest) begin
        check("burst_expected", 64'(exp_burst.size() != 0), 64'd1);
        if (exp_burst.size() != 0) begin
          mb = exp_burst.pop_front();
          check("burst", 64'({avm_address, avm_burstcount}), 64'({mb.addr, 5'(mb.bc)}));
        end
        for (int j = 0; j < int'(avm_burstcount); j++)
          beat_addr.push_back(avm_address + 32'(BYTES * j));
      end
      if (done) begin
        check("done_expected", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0) begin
          md = exp_done.pop_front();
          check("done_err", 64'(err), 64'(md.err));
          if (md.short_req) check("short_done_latency", 64'(cyc), 64'(md.start_cyc + 2));
          else check("eop_with_done", 64'({fifo_wr, fifo_eop}), 64'd3);
          check("words_outstanding", 64'(exp_word.size() + exp_burst.size()), 64'd0);
        end
      end
      if (done_prev) check("busy_after_done", 64'(busy), 64'd0);
      prev_read = avm_read; prev_wait = avm_waitrequest; prev_addr = avm_address;
      prev_bc = avm_burstcount; rdv_prev = avm_readdatavalid; stale_prev = rdv_stale;
      af_prev = fifo_almost_full; done_prev = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b, e;
    #1 reset = 1'b0;
    #1 check_outputs_zero("reset_initial");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    run_req(32'h1000, 32'h1040, 0); wait_done();
    run_req(32'h1000, 32'h100A, 0); wait_done();
    run_req(32'h1030, 32'h1070, 0); wait_done();

    af_arm = 1'b1; af_drop_expect = 1'b1;
    run_req(32'h2000, 32'h2080, 0); wait_done();

    run_req(32'h4000, 32'h4020, 7);
    @(posedge clk); #1;
    start = 1'b1; pkt_begin = 32'h0; pkt_end = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    run_req(32'h1040, 32'h1000, 0); wait_done();
    run_req(32'h1002, 32'h1010, 0); wait_done();
    run_req(32'h1000, 32'h1000, 0); wait_done();
    run_req(32'h0000, 32'h1_0000, 0); wait_done();

    run_req(32'h3000, 32'h3100, 0);
    for (int k = 0; k < 2000 && exp_word.size() > 50; k++) @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    #1 check_outputs_zero("reset_midburst");
    flush();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    stale_n = 3;
    repeat (6) @(posedge clk);
    run_req(32'h5004, 32'h5047, 0); wait_done();

    for (int i = 0; i < 30; i++) begin
      b = 32'h8000 + 32'($urandom_range(0, 255)) * 4;
      e = b + 32'($urandom_range(0, 160));
      case ($urandom_range(0, 9))
        0: b = b + 32'($urandom_range(1, 3));
        1: e = b - 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_req(b, e, 0);
      wait_done();
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
